rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Round-robin arbiter sharing one synchronous, registered-read ROM among up to NUM_REQ requesters (sprite and text drawing units of the display pipeline). It accepts one read per cycle, drives the ROM enable and address, and tracks in-flight reads through the ROM latency. It returns each word with a one-hot valid tag identifying its requester. A lock input lets a requester hold the ROM for back-to-back burst reads (e.g. one sprite line).

## Interface
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 16, ROM word width
- NUM_REQ, 4, number of requesters, 2..8 (power of two not required)
- ROM_LATENCY, 1, cycles from ROM address sample to valid rom_dout, 1..4
- clk  in  1  posedge clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  request per requester; held with its addr until granted
- lock  in  NUM_REQ  requester asks to keep ownership after this grant
- addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, combinational, valid in the cycle of acceptance
- rom_en  out  1  ROM read enable, high iff a grant is issued this cycle
- rom_addr  out  ADDR_WIDTH  address of granted requester; 0 when rom_en low
- rom_dout  in  DATA_WIDTH  ROM read data
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  NUM_REQ  registered one-hot tag, one-cycle pulse per returned word

## Operation
- Transfer occurs in any cycle where req[i] && gnt[i]; at most one gnt bit high per cycle.
- State: ptr (round-robin priority start, 0..NUM_REQ-1), owner (requester index), FSM {ARB, LOCKED}.
- ARB: grant first requester with req high scanning ptr, ptr+1, ... wrapping mod NUM_REQ. On grant to i: if lock[i], owner<=i, go LOCKED, ptr unchanged; else ptr<=(i+1) mod NUM_REQ. No request -> no grant, state unchanged.
- LOCKED: only owner can be granted; other requests wait. req[owner] && lock[owner] -> grant, stay LOCKED. req[owner] && !lock[owner] -> grant (last of burst), ptr<=(owner+1) mod NUM_REQ, go ARB. !req[owner] -> no grant this cycle, ptr<=(owner+1) mod NUM_REQ, go ARB (one bubble).
- Tag pipeline: ROM_LATENCY+1 stage shift register of {valid, index}; stage 0 loaded with the grant; word for index emerges with rom_dout and is registered into rd_data/rd_valid.
- rd_data holds its last value while rd_valid is all-zero.
- Reset (async, any time): ptr=0, owner=0, FSM=ARB, tag pipeline cleared, rd_valid=0, rd_data=0. In-flight reads are discarded; no rd_valid pulse for them after release. gnt/rom_en combinational, low while rst_n low.

## Timing
- Grant at cycle T: rom_addr presented in T, sampled by ROM at end of T, rom_dout valid in T+ROM_LATENCY, rd_data/rd_valid visible in T+ROM_LATENCY+1 (T+2 at default).
- Throughput: one word per cycle, full pipelining, returns in grant order.
- Fairness: with all NUM_REQ requesting and no lock, each requester granted exactly once per NUM_REQ cycles.
- Requester deasserting req in the grant cycle's following cycle is legal; req/addr changes before grant are legal (no ordering guarantee for unaccepted requests).
- Lock burst length unbounded; fairness is the requesters' responsibility.

## Test plan
- Reset, req=0001, addr[0]=0x12, ROM word 0x12=0xBEEF -> gnt=0001 and rom_addr=0x12 in T, rd_valid=0001 and rd_data=0xBEEF in T+2, rd_valid=0 otherwise.
- req=1111 held 8 cycles, no lock -> gnt sequence 0001,0010,0100,1000,0001,...; rd_valid same sequence delayed 2 cycles, data matches each addr.
- Requester 2 locks burst of 4 (lock high for first 3) while req=1111 -> gnt=0100 for 4 consecutive cycles, then 1000, 0001; ptr=3 after burst.
- LOCKED owner drops req -> one cycle with gnt=0 and rom_en=0, next cycle grant to (owner+1) mod NUM_REQ if requesting.
- rst_n pulsed low while 2 reads in flight -> rd_valid=0 immediately, no pulses after release, first grant after reset goes to lowest-indexed requester.
- NUM_REQ=3, ROM_LATENCY=3, req=111 -> gnt wraps 001,010,100,001; rd_valid delayed 4 cycles.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among NUM_REQ requesters,
// with lockable bursts and a tag pipeline that returns each word with a one-hot requester tag.
module rom_arbiter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REQ     = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]            rd_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] gnt_idx, cidx;
    logic             found;

    logic             tag_v   [ROM_LATENCY];
    logic [IDX_W-1:0] tag_idx [ROM_LATENCY];
    logic [NUM_REQ-1:0] ret_oh;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (32'(i) == NUM_REQ - 1)
            return '0;
        return i + 1'b1;
    endfunction

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cidx    = '0;
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        case (state)
            ARB: begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cidx = IDX_W'((32'(ptr) + k) % NUM_REQ);
                    if (!found && req[cidx]) begin
                        found   = 1'b1;
                        gnt_idx = cidx;
                    end
                end
                if (found) begin
                    if (lock[gnt_idx]) begin
                        owner_n = gnt_idx;
                        state_n = LOCKED;
                    end else begin
                        ptr_n = next_idx(gnt_idx);
                    end
                end
            end
            LOCKED: begin
                // Owner dropping req ends the burst with a bubble cycle.
                if (req[owner]) begin
                    found   = 1'b1;
                    gnt_idx = owner;
                    if (!lock[owner]) begin
                        ptr_n   = next_idx(owner);
                        state_n = ARB;
                    end
                end else begin
                    ptr_n   = next_idx(owner);
                    state_n = ARB;
                end
            end
            default: state_n = ARB;
        endcase

        rom_en   = found && rst_n;
        rom_addr = rom_en ? addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        gnt      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            gnt[i] = rom_en && (gnt_idx == IDX_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
        end
    end

    // Tag stage ROM_LATENCY-1 lines up with rom_dout; rd_valid is the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= rom_en;
            tag_idx[0] <= gnt_idx;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_comb begin
        ret_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            ret_oh[i] = tag_v[ROM_LATENCY-1] && (tag_idx[ROM_LATENCY-1] == IDX_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= ret_oh;
            if (tag_v[ROM_LATENCY-1])
                rd_data <= rom_dout;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: default config (4 req, latency 1) and a
// 3-requester latency-3 config, with a scoreboard of expected read returns.
module tb_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]  req_a, lock_a, gnt_a, rdv_a;
    logic [31:0] addr_a;
    logic        rom_en_a;
    logic [7:0]  rom_addr_a;
    logic [15:0] rom_dout_a, rd_data_a;

    logic [2:0]  req_b, lock_b, gnt_b, rdv_b;
    logic [23:0] addr_b;
    logic        rom_en_b;
    logic [7:0]  rom_addr_b;
    logic [15:0] rom_dout_b, rd_data_b;

    rom_arbiter dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .lock(lock_a), .addr(addr_a),
        .gnt(gnt_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_dout(rom_dout_a),
        .rd_data(rd_data_a), .rd_valid(rdv_a)
    );

    rom_arbiter #(.NUM_REQ(3), .ROM_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .lock(lock_b), .addr(addr_b),
        .gnt(gnt_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_dout(rom_dout_b),
        .rd_data(rd_data_b), .rd_valid(rdv_b)
    );

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (a == 8'h12)
            return 16'hBEEF;
        return {a ^ 8'h5A, ~a};
    endfunction

    // ROM models: latency 1 for dut_a, latency 3 for dut_b
    logic [15:0] pb0, pb1;
    always @(posedge clk) begin
        if (rom_en_a) rom_dout_a <= rom_word(rom_addr_a);
        if (rom_en_b) pb0 <= rom_word(rom_addr_b);
        pb1        <= pb0;
        rom_dout_b <= pb1;
    end

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [15:0] data;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int cyc = 0;
    int checks = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int c, input logic [3:0] t, input logic [15:0] d);
        exp_t e;
        e.cyc = c; e.tag = t; e.data = d;
        return e;
    endfunction

    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            checks++; fails++;
            ea = qa.pop_front();
            $display("FAIL rd_missing_a: tag %b due cycle %0d not seen", ea.tag, ea.cyc);
        end
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            ea = qa.pop_front();
            checks++;
            if (rdv_a !== ea.tag || rd_data_a !== ea.data) begin
                fails++;
                $display("FAIL rd_return_a cyc %0d: got %b/%h, expected %b/%h",
                         cyc, rdv_a, rd_data_a, ea.tag, ea.data);
            end
        end else begin
            checks++;
            if (rdv_a !== 4'b0000) begin
                fails++;
                $display("FAIL rd_idle_a cyc %0d: rd_valid %b, expected 0000", cyc, rdv_a);
            end
        end
    end

    always @(negedge clk) begin
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            checks++; fails++;
            eb = qb.pop_front();
            $display("FAIL rd_missing_b: tag %b due cycle %0d not seen", eb.tag, eb.cyc);
        end
        if (qb.size() > 0 && qb[0].cyc == cyc) begin
            eb = qb.pop_front();
            checks++;
            if (rdv_b !== eb.tag[2:0] || rd_data_b !== eb.data) begin
                fails++;
                $display("FAIL rd_return_b cyc %0d: got %b/%h, expected %b/%h",
                         cyc, rdv_b, rd_data_b, eb.tag[2:0], eb.data);
            end
        end else begin
            checks++;
            if (rdv_b !== 3'b000) begin
                fails++;
                $display("FAIL rd_idle_b cyc %0d: rd_valid %b, expected 000", cyc, rdv_b);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        req_a = '0; lock_a = '0; req_b = '0; lock_b = '0;
        qa.delete(); qb.delete();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_a = 4'hF;
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0000 || rom_en_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_gnt: gnt %b rom_en %b, expected 0000/0", gnt_a, rom_en_a);
        end
        checks++;
        if (rdv_a !== 4'b0000 || rd_data_a !== 16'h0000 || rdv_b !== 3'b000 || rd_data_b !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rd: a %b/%h b %b/%h, expected zeros", rdv_a, rd_data_a, rdv_b, rd_data_b);
        end
        req_a = '0;
        next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();
    endtask

    task automatic test_single();
        next_cycle();
        req_a  = 4'b0001;
        addr_a = 32'h0000_0012;
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0001 || rom_en_a !== 1'b1 || rom_addr_a !== 8'h12) begin
            fails++;
            $display("FAIL single_grant: gnt %b en %b addr %h, expected 0001/1/12", gnt_a, rom_en_a, rom_addr_a);
        end
        qa.push_back(mk(cyc + 2, 4'b0001, 16'hBEEF));
        next_cycle();
        req_a = '0;
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0000 || rom_en_a !== 1'b0 || rom_addr_a !== 8'h00) begin
            fails++;
            $display("FAIL single_idle: gnt %b en %b addr %h, expected 0000/0/00", gnt_a, rom_en_a, rom_addr_a);
        end
        repeat (4) next_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] ea8;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_a = 4'hF;
            for (int i = 0; i < 4; i++) addr_a[i*8 +: 8] = 8'(32 + k*4 + i);
            @(negedge clk);
            eg  = 4'b0001 << (k % 4);
            ea8 = 8'(32 + k*4 + (k % 4));
            checks++;
            if (gnt_a !== eg || rom_addr_a !== ea8) begin
                fails++;
                $display("FAIL rr_grant k=%0d: gnt %b addr %h, expected %b/%h", k, gnt_a, rom_addr_a, eg, ea8);
            end
            qa.push_back(mk(cyc + 2, eg, rom_word(ea8)));
        end
        next_cycle();
        req_a = '0;
        repeat (4) next_cycle();
    endtask

    task automatic test_lock_burst();
        int iseq[8] = '{0, 1, 2, 2, 2, 2, 3, 0};
        logic [3:0] lseq[8] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
        logic [3:0] eg;
        do_reset();
        addr_a = {8'h63, 8'h62, 8'h61, 8'h60};
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_a  = 4'hF;
            lock_a = lseq[k];
            @(negedge clk);
            eg = 4'b0001 << iseq[k];
            checks++;
            if (gnt_a !== eg) begin
                fails++;
                $display("FAIL lock_grant k=%0d: gnt %b, expected %b", k, gnt_a, eg);
            end
            qa.push_back(mk(cyc + 2, eg, rom_word(8'(8'h60 + iseq[k]))));
        end
        next_cycle();
        req_a = '0; lock_a = '0;
        repeat (4) next_cycle();
    endtask

    task automatic test_owner_drop();
        do_reset();
        addr_a = {8'h73, 8'h72, 8'h71, 8'h70};
        next_cycle();
        req_a = 4'b0010; lock_a = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0010) begin
            fails++;
            $display("FAIL drop_lockgrant: gnt %b, expected 0010", gnt_a);
        end
        qa.push_back(mk(cyc + 2, 4'b0010, rom_word(8'h71)));
        next_cycle();
        req_a = 4'b1101; lock_a = '0;
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0000 || rom_en_a !== 1'b0) begin
            fails++;
            $display("FAIL drop_bubble: gnt %b en %b, expected 0000/0", gnt_a, rom_en_a);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0100) begin
            fails++;
            $display("FAIL drop_next: gnt %b, expected 0100", gnt_a);
        end
        qa.push_back(mk(cyc + 2, 4'b0100, rom_word(8'h72)));
        next_cycle();
        req_a = '0;
        repeat (4) next_cycle();
    endtask

    task automatic test_reset_inflight();
        logic [3:0] eg;
        do_reset();
        addr_a = {8'h83, 8'h82, 8'h81, 8'h80};
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req_a = 4'hF;
            @(negedge clk);
            eg = 4'b0001 << k;
            checks++;
            if (gnt_a !== eg) begin
                fails++;
                $display("FAIL inflight_grant k=%0d: gnt %b, expected %b", k, gnt_a, eg);
            end
            qa.push_back(mk(cyc + 2, eg, rom_word(8'(8'h80 + k))));
        end
        #1;
        rst_n = 1'b0;
        req_a = '0;
        qa.delete();
        #1;
        checks++;
        if (rdv_a !== 4'b0000 || rd_data_a !== 16'h0000) begin
            fails++;
            $display("FAIL inflight_clear: rd_valid %b rd_data %h, expected 0000/0000", rdv_a, rd_data_a);
        end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (4) next_cycle();
        next_cycle();
        req_a = 4'b0110;
        @(negedge clk);
        checks++;
        if (gnt_a !== 4'b0010) begin
            fails++;
            $display("FAIL post_reset_grant: gnt %b, expected 0010", gnt_a);
        end
        qa.push_back(mk(cyc + 2, 4'b0010, rom_word(8'h81)));
        next_cycle();
        req_a = '0;
        repeat (4) next_cycle();
    endtask

    task automatic test_wrap3_lat3();
        logic [2:0] eg;
        do_reset();
        addr_b = {8'h92, 8'h91, 8'h90};
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            req_b = 3'b111;
            @(negedge clk);
            eg = 3'b001 << (k % 3);
            checks++;
            if (gnt_b !== eg) begin
                fails++;
                $display("FAIL wrap3_grant k=%0d: gnt %b, expected %b", k, gnt_b, eg);
            end
            qb.push_back(mk(cyc + 4, {1'b0, eg}, rom_word(8'(8'h90 + k % 3))));
        end
        next_cycle();
        req_b = '0;
        repeat (6) next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0; lock_a = '0; addr_a = '0;
        req_b = '0; lock_b = '0; addr_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_owner_drop();
        test_reset_inflight();
        test_wrap3_lat3();
        @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d returns outstanding, expected 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
